dmux16_stream: RTL

- Streaming 16-bit demultiplexer: the write-side counterpart of the Mux16 2:1 selector.
- Accepts one word per cycle on a valid/ready input channel and steers it to output channel A or B.
- Each output channel has a one-entry holding buffer with its own valid/ready handshake.
- Sits between a single word producer and two independent consumers, such as a memory write port and an I/O register.

---
 rtl/dmux16_pkg.sv | 23 ++
 rtl/dmux16_slot.sv | 84 ++++++++
 rtl/dmux16_stream.sv | 113 +++++++++++
 3 files changed

// File: rtl/dmux16_pkg.sv
// ---------------------------------------------------------------------------
// dmux16_pkg
// Shared definitions for the dmux16_stream demultiplexer:
//   WIDTH_DEF / CNT_WIDTH_DEF : default data and counter widths
//   channel_e                 : output channel identifier (A = 0, B = 1)
//   slot_state_e              : occupancy state of a one-entry output buffer
// ---------------------------------------------------------------------------
package dmux16_pkg;

  localparam int WIDTH_DEF     = 16;
  localparam int CNT_WIDTH_DEF = 8;

  typedef enum logic {
    CH_A = 1'b0,
    CH_B = 1'b1
  } channel_e;

  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_state_e;

endpackage : dmux16_pkg

// File: rtl/dmux16_slot.sv
// ---------------------------------------------------------------------------
// dmux16_slot
// One-entry output buffer with valid/ready handshake and a delivered-word
// counter. A load and a drain in the same cycle reload the buffer without a
// bubble, so a ready consumer sustains one word per cycle.
//
// Ports:
//   clk, reset  : rising-edge clock, asynchronous active-high reset
//   load_i      : write data_i into the buffer this cycle (only when free_o)
//   data_i      : word to store
//   data_o      : buffered word (held stable while valid_o && !ready_i)
//   valid_o     : buffer full
//   ready_i     : consumer takes the word at this edge
//   free_o      : buffer can take a word this cycle (empty or draining)
//   cnt_o       : words delivered to the consumer, wraps at 2^CNT_WIDTH
// ---------------------------------------------------------------------------
module dmux16_slot
  import dmux16_pkg::*;
#(
  parameter int WIDTH     = WIDTH_DEF,
  parameter int CNT_WIDTH = CNT_WIDTH_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 load_i,
  input  logic [WIDTH-1:0]     data_i,
  output logic [WIDTH-1:0]     data_o,
  output logic                 valid_o,
  input  logic                 ready_i,
  output logic                 free_o,
  output logic [CNT_WIDTH-1:0] cnt_o
);

  slot_state_e          state_q, state_d;
  logic [WIDTH-1:0]     data_q, data_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 drain;

  // Output handshake completes at the coming edge.
  assign drain = (state_q == SLOT_FULL) && ready_i;

  // State register. The data word is reset too: it is a visible output
  // and must read 0 after reset.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples the
  // pre-edge values of its neighbours; blocking here would create ordering
  // dependencies between always blocks.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= SLOT_EMPTY;
      data_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic.
  // NOTE: every signal assigned in always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      SLOT_EMPTY: if (load_i)           state_d = SLOT_FULL;
      SLOT_FULL:  if (drain && !load_i) state_d = SLOT_EMPTY;
      default:                          state_d = SLOT_EMPTY;
    endcase
    // After draining the old word stays on data_o; it is don't-care then.
    if (load_i) data_d = data_i;
    if (drain)  cnt_d  = cnt_q + CNT_WIDTH'(1);
  end

  // Outputs.
  always_comb begin
    valid_o = (state_q == SLOT_FULL);
    free_o  = (state_q == SLOT_EMPTY) || drain;
    data_o  = data_q;
    cnt_o   = cnt_q;
  end

endmodule : dmux16_slot

// File: rtl/dmux16_stream.sv
// ---------------------------------------------------------------------------
// dmux16_stream
// Streaming 1:2 demultiplexer. One word per cycle is accepted on a
// valid/ready input and steered to output channel A or B, each backed by a
// one-entry buffer (dmux16_slot) with its own handshake and counter.
//
// Configuration macro: DMUX16_ROUND_ROBIN_EN
//   undefined : in_sel picks the target channel (0 = A, 1 = B)
//   defined   : in_sel is ignored; an internal pointer (reset to A) picks the
//               target and toggles after every accepted word. Alternation is
//               strict: a stalled target blocks input even if the other
//               channel is empty.
//
// Ports:
//   clk, reset                  : rising-edge clock, async active-high reset
//   in_data, in_sel             : word and destination, sampled on accept
//   in_valid / in_ready         : input handshake (in_ready is combinational
//                                 and depends only on the target channel)
//   out_a, out_a_valid/_ready   : channel A output and handshake
//   out_b, out_b_valid/_ready   : channel B output and handshake
//   cnt_a, cnt_b                : delivered-word counters (wrap)
//   busy                        : either output buffer holds a word
// ---------------------------------------------------------------------------
module dmux16_stream
  import dmux16_pkg::*;
#(
  parameter int WIDTH     = WIDTH_DEF,
  parameter int CNT_WIDTH = CNT_WIDTH_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [WIDTH-1:0]     in_data,
  input  logic                 in_sel,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [WIDTH-1:0]     out_a,
  output logic                 out_a_valid,
  input  logic                 out_a_ready,
  output logic [WIDTH-1:0]     out_b,
  output logic                 out_b_valid,
  input  logic                 out_b_ready,
  output logic [CNT_WIDTH-1:0] cnt_a,
  output logic [CNT_WIDTH-1:0] cnt_b,
  output logic                 busy
);

  channel_e target;
  logic     free_a, free_b;
  logic     target_free;
  logic     accept;
  logic     load_a, load_b;

`ifdef DMUX16_ROUND_ROBIN_EN
  channel_e ptr_q, ptr_d;
  logic     unused_in_sel;

  assign unused_in_sel = in_sel;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) ptr_q <= CH_A;
    else       ptr_q <= ptr_d;
  end

  always_comb begin
    ptr_d = ptr_q;
    if (accept) ptr_d = (ptr_q == CH_A) ? CH_B : CH_A;
  end

  assign target = ptr_q;
`else
  assign target = channel_e'(in_sel);
`endif

  // Only the target channel gates input; the other channel is never looked at.
  assign target_free = (target == CH_A) ? free_a : free_b;
  assign in_ready    = !reset && target_free;
  assign accept      = in_valid && in_ready;
  assign load_a      = accept && (target == CH_A);
  assign load_b      = accept && (target == CH_B);

  dmux16_slot #(
    .WIDTH     (WIDTH),
    .CNT_WIDTH (CNT_WIDTH)
  ) u_slot_a (
    .clk     (clk),
    .reset   (reset),
    .load_i  (load_a),
    .data_i  (in_data),
    .data_o  (out_a),
    .valid_o (out_a_valid),
    .ready_i (out_a_ready),
    .free_o  (free_a),
    .cnt_o   (cnt_a)
  );

  dmux16_slot #(
    .WIDTH     (WIDTH),
    .CNT_WIDTH (CNT_WIDTH)
  ) u_slot_b (
    .clk     (clk),
    .reset   (reset),
    .load_i  (load_b),
    .data_i  (in_data),
    .data_o  (out_b),
    .valid_o (out_b_valid),
    .ready_i (out_b_ready),
    .free_o  (free_b),
    .cnt_o   (cnt_b)
  );

  assign busy = out_a_valid || out_b_valid;

endmodule : dmux16_stream
